// File: rtl/dmi_dtm_sequencer.sv
// dmi_dtm_sequencer: DTM-side DMI initiator, one outstanding transaction with sticky dmistat.
// Optional abort timer enabled by defining DMI_SEQ_TIMEOUT_EN.
module dmi_dtm_sequencer #(
    parameter int AddrWidth     = 7,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 update_i,
    input  logic [1:0]           update_op_i,
    input  logic [AddrWidth-1:0] update_addr_i,
    input  logic [31:0]          update_data_i,
    input  logic                 capture_i,
    output logic [AddrWidth-1:0] capture_addr_o,
    output logic [31:0]          capture_data_o,
    output logic [1:0]           capture_op_o,
    input  logic                 dmireset_i,
    input  logic                 dmihardreset_i,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth+33:0] dmi_req_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [33:0]          dmi_resp_i,
    output logic [1:0]           dmistat_o,
    output logic                 busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    state_e               state, state_n;
    logic [1:0]           error_q, err_eff, error_n;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          data_q;
    logic                 start, req_hs, rsp_hs, rsp_fail, timeout;

    // dmireset clears first so same-cycle events see a clean error
    assign err_eff  = dmireset_i ? 2'd0 : error_q;
    assign start    = update_i && state == IDLE && err_eff == 2'd0 && !dmihardreset_i &&
                      (update_op_i == 2'd1 || update_op_i == 2'd2);
    assign req_hs   = dmi_req_valid_o && dmi_req_ready_i;
    assign rsp_hs   = dmi_resp_valid_i && dmi_resp_ready_o;
    assign rsp_fail = rsp_hs && dmi_resp_i[1:0] != 2'd0;

`ifdef DMI_SEQ_TIMEOUT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i || start)
            cnt <= '0;
        else if (busy_o)
            cnt <= cnt + 16'd1;
    end
    assign timeout = busy_o && !rsp_hs && cnt == 16'(TimeoutCycles - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = (dmihardreset_i || timeout) ? IDLE :
                  start                       ? REQ  :
                  (state == REQ && req_hs)    ? RSP  :
                  (state == RSP && rsp_hs)    ? IDLE : state;
    end

    always_comb begin
        dmi_req_valid_o  = state == REQ;
        dmi_resp_ready_o = state == RSP;
        busy_o           = state != IDLE;
    end

    always_comb begin
        error_n = dmihardreset_i                                 ? 2'd0 :
                  timeout                                        ? 2'd2 :
                  (err_eff == 2'd0 && rsp_fail)                  ? 2'd2 :
                  (err_eff == 2'd0 && busy_o && (update_i || capture_i)) ? 2'd3 : err_eff;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q        <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            dmi_req_o      <= '0;
            capture_addr_o <= '0;
            capture_data_o <= '0;
            capture_op_o   <= '0;
        end else begin
            error_q <= error_n;
            if (start) begin
                addr_q    <= update_addr_i;
                dmi_req_o <= {update_addr_i, update_op_i, update_data_i};
            end
            if (rsp_hs && !dmihardreset_i)
                data_q <= dmi_resp_i[33:2];
            // capture reflects the state before any same-cycle update
            if (capture_i) begin
                capture_addr_o <= addr_q;
                capture_data_o <= data_q;
                capture_op_o   <= busy_o ? 2'd3 : err_eff;
            end
        end
    end

    assign dmistat_o = error_q;
endmodule
